// File: rtl/mmio_timer_pkg.sv
// rtl/mmio_timer_pkg.sv - register map, field positions and reset values for mmio_timer
package mmio_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_AUTOCLR  = 1;
    localparam int CTRL_IE       = 2;
    localparam int PRESCALE_LSB  = 8;
    localparam int PRESCALE_MSB  = 15;

    localparam int STATUS_MATCH  = 0;
    localparam int STATUS_OVF    = 1;

    localparam logic [31:0] CTRL_MASK     = 32'h0000_FF07;
    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides the clock into one tick every prescale+1 cycles
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] cnt;

    // A clear cycle never ticks, so a rewrite restarts the full period.
    assign tick = en && !clr && (cnt == prescale);

    always_ff @(posedge clk) begin
        if (reset || clr || !en) begin
            cnt <= 8'd0;
        end else if (cnt == prescale) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped 32-bit timer with compare, overflow and interrupt
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        hit,
    output logic        irq
);

    logic [31:0] ctrl;
    logic [31:0] count;
    logic [31:0] compare;
    logic [1:0]  status;
    logic [31:0] count_next;
    logic [1:0]  status_next;
    logic [1:0]  w1c;
    logic        tick;
    logic        wr_ctrl, wr_count, wr_compare, wr_status;
    logic        match_evt, ovf_evt;
    logic        unused_addr_bits;
    reg_sel_e    sel;

    assign hit = (memaddr[31:4] == BASE_ADDR[31:4]);
    assign sel = reg_sel_e'(memaddr[3:2]);
    assign unused_addr_bits = &{1'b0, memaddr[1:0]};

    assign wr_ctrl    = memwrite && hit && (sel == REG_CTRL);
    assign wr_count   = memwrite && hit && (sel == REG_COUNT);
    assign wr_compare = memwrite && hit && (sel == REG_COMPARE);
    assign wr_status  = memwrite && hit && (sel == REG_STATUS);

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl[CTRL_EN]),
        .clr      (wr_ctrl),
        .prescale (ctrl[PRESCALE_MSB:PRESCALE_LSB]),
        .tick     (tick)
    );

    // A CPU write to COUNT discards every effect of a same-cycle tick.
    assign match_evt = tick && !wr_count && (count == compare);
    assign ovf_evt   = tick && !wr_count && (count == 32'hFFFF_FFFF);
    assign w1c       = wr_status ? memwritedata[1:0] : 2'b00;

    always_comb begin
        count_next = count;
        if (wr_count) begin
            count_next = memwritedata;
        end else if (tick) begin
            if (match_evt && ctrl[CTRL_AUTOCLR]) begin
                count_next = 32'd0;
            end else begin
                count_next = count + 32'd1;
            end
        end
    end

    always_comb begin
        status_next = status & ~w1c;
        status_next[STATUS_MATCH] = status_next[STATUS_MATCH] | match_evt;
        status_next[STATUS_OVF]   = status_next[STATUS_OVF] | ovf_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= 32'd0;
            count   <= 32'd0;
            compare <= COMPARE_RESET;
            status  <= 2'b00;
            irq     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= memwritedata & CTRL_MASK;
            end
            if (wr_compare) begin
                compare <= memwritedata;
            end
            count  <= count_next;
            status <= status_next;
            irq    <= ctrl[CTRL_IE] & status[STATUS_MATCH];
        end
    end

    always_comb begin
        memreaddata = 32'd0;
        if (hit) begin
            case (sel)
                REG_CTRL:    memreaddata = ctrl;
                REG_COUNT:   memreaddata = count;
                REG_COMPARE: memreaddata = compare;
                REG_STATUS:  memreaddata = {30'd0, status};
                default:     memreaddata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed self-checking bench for mmio_timer
module tb_mmio_timer;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_CNT  = BASE + 32'h4;
    localparam logic [31:0] A_CMP  = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = 32'd0;
    logic [31:0] memwritedata = 32'd0;
    logic [31:0] memreaddata;
    logic        hit;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .hit          (hit),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memaddr = a;
        memwritedata = d;
        memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        memaddr = a;
        #1;
        d = memreaddata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        step(2);
        rd(A_CTRL, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want %h", v, 32'h0); end
        rd(A_CNT, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want %h", v, 32'h0); end
        rd(A_CMP, v); checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare: got %h want %h", v, 32'hFFFF_FFFF); end
        rd(A_STAT, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want %h", v, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++;
        if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit: got %b want 1", hit); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_decode();
        logic [31:0] v;
        rd(BASE + 32'h10, v); checks++;
        if (hit !== 1'b0 || v !== 32'h0) begin
            errors++; $display("FAIL miss_read: hit %b data %h want hit 0 data 0", hit, v);
        end
        rd(BASE + 32'hB, v); checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL byte_offset_ignored: got %h want %h", v, 32'hFFFF_FFFF); end
        wr(BASE + 32'h18, 32'h0);
        rd(A_CMP, v); checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL miss_write: got %h want %h", v, 32'hFFFF_FFFF); end
        wr(A_CTRL, 32'hFFFF_FFF8);
        rd(A_CTRL, v); checks++;
        if (v !== 32'h0000_FF00) begin errors++; $display("FAIL ctrl_mask: got %h want %h", v, 32'h0000_FF00); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_autoclr_match();
        logic [31:0] v;
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h7);
        step(5);
        rd(A_CNT, v); checks++;
        if (v !== 32'd5) begin errors++; $display("FAIL autoclr_count5: got %h want %h", v, 32'd5); end
        rd(A_STAT, v); checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL autoclr_nomatch_yet: got %h want %h", v, 32'd0); end
        step(1);
        rd(A_STAT, v); checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL autoclr_match: got %h want %h", v, 32'd1); end
        rd(A_CNT, v); checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL autoclr_count0: got %h want %h", v, 32'd0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_not_early: got %b want 0", irq); end
        step(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_match: got %b want 1", irq); end
        wr(A_STAT, 32'd1);
        rd(A_STAT, v); checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL match_w1c: got %h want %h", v, 32'd0); end
        step(4);
        rd(A_STAT, v); checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL match_repeat: got %h want %h", v, 32'd1); end
        rd(A_CNT, v); checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL repeat_count0: got %h want %h", v, 32'd0); end
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'd1);
        step(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b want 0", irq); end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h0301);
        step(3);
        rd(A_CNT, v); checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL pre_before_tick: got %h want %h", v, 32'd0); end
        step(1);
        rd(A_CNT, v); checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL pre_first_tick: got %h want %h", v, 32'd1); end
        step(4);
        rd(A_CNT, v); checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL pre_second_tick: got %h want %h", v, 32'd2); end
        step(1);
        wr(A_CTRL, 32'h0301);
        step(3);
        rd(A_CNT, v); checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL pre_rewrite_restart: got %h want %h", v, 32'd2); end
        step(1);
        rd(A_CNT, v); checks++;
        if (v !== 32'd3) begin errors++; $display("FAIL pre_rewrite_tick: got %h want %h", v, 32'd3); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);
        step(1);
        rd(A_CNT, v); checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_count_max: got %h want %h", v, 32'hFFFF_FFFF); end
        step(1);
        rd(A_CNT, v); checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL ovf_wrap: got %h want %h", v, 32'd0); end
        rd(A_STAT, v); checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL ovf_flag: got %h want %h", v, 32'd2); end
        wr(A_STAT, 32'd2);
        rd(A_STAT, v); checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL ovf_w1c: got %h want %h", v, 32'd0); end
        wr(A_CTRL, 32'h0);
        wr(A_CNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        wr(A_STAT, 32'd2);
        rd(A_STAT, v); checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL ovf_set_beats_w1c: got %h want %h", v, 32'd2); end
        wr(A_STAT, 32'd2);
        rd(A_STAT, v); checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL ovf_w1c_after: got %h want %h", v, 32'd0); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_compare_write();
        logic [31:0] v;
        wr(A_CNT, 32'd10);
        wr(A_CMP, 32'd12);
        wr(A_CTRL, 32'h1);
        step(2);
        wr(A_CMP, 32'd50);
        rd(A_STAT, v); checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL match_old_compare: got %h want %h", v, 32'd1); end
        rd(A_CMP, v); checks++;
        if (v !== 32'd50) begin errors++; $display("FAIL compare_written: got %h want %h", v, 32'd50); end
        step(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_ie_gated: got %b want 0", irq); end
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'd1);
    endtask

    task automatic test_count_write_and_reset();
        logic [31:0] v;
        wr(A_CTRL, 32'h5);
        step(2);
        wr(A_CNT, 32'd100);
        rd(A_CNT, v); checks++;
        if (v !== 32'd100) begin errors++; $display("FAIL count_write_wins: got %h want %h", v, 32'd100); end
        step(1);
        rd(A_CNT, v); checks++;
        if (v !== 32'd101) begin errors++; $display("FAIL count_after_write: got %h want %h", v, 32'd101); end
        wr(A_CMP, 32'd102);
        step(2);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_reset: got %b want 1", irq); end
        memaddr = A_CNT;
        memwritedata = 32'd55;
        memwrite = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        reset = 1'b0;
        rd(A_CTRL, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL midreset_ctrl: got %h want %h", v, 32'h0); end
        rd(A_CNT, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL midreset_count: got %h want %h", v, 32'h0); end
        rd(A_CMP, v); checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset_compare: got %h want %h", v, 32'hFFFF_FFFF); end
        rd(A_STAT, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want %h", v, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_autoclr_match();
        test_prescale();
        test_overflow();
        test_compare_write();
        test_count_write_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
